dram_txn_gate: RTL and testbench

- Upstream neighbour of the DRAM wrapper, clocked in the SoC domain.
- Sits between the SoC DRAM crossbar port and the wrapper's `soc_req_i`/`soc_rsp_o`.
- Holds off AXI traffic until memory calibration completes and caps outstanding reads and writes per direction.
- Provides a drain/quiesce handshake so software or a reset controller can empty the DRAM path before a DRAM reset or a clock change.

---
 rtl/dram_txn_gate_pkg.sv | 42 ++++
 rtl/dram_txn_gate.sv | 107 ++++++++++
 tb/tb_dram_txn_gate.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dram_txn_gate_pkg.sv
// dram_txn_gate_pkg: default SoC AXI request/response struct types for dram_txn_gate
package dram_txn_gate_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;
  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    logic b_valid;
    b_t   b;
    logic r_valid;
    r_t   r;
  } axi_resp_t;
endpackage

// File: rtl/dram_txn_gate.sv
// dram_txn_gate: holds off AXI traffic until DRAM calibration, caps outstanding reads/writes, and drains on request
// Ports: clk_i/rst_ni (async active-low), calib_done_i, drain_req_i, slv_req_i/slv_rsp_o (SoC side),
//        mst_req_o/mst_rsp_i (DRAM wrapper side), rd_outstanding_o, wr_outstanding_o, drained_o, timeout_o.
// Optional: define DRAM_TXN_GATE_TIMEOUT_EN to enable the sticky stalled-response watchdog on timeout_o.
module dram_txn_gate #(
  parameter int unsigned MaxReadTxns   = 8,
  parameter int unsigned MaxWriteTxns  = 8,
  parameter int unsigned TimeoutCycles = 65536,
  parameter type axi_req_t  = dram_txn_gate_pkg::axi_req_t,
  parameter type axi_resp_t = dram_txn_gate_pkg::axi_resp_t,
  localparam int unsigned RdW = $clog2(MaxReadTxns + 1),
  localparam int unsigned WrW = $clog2(MaxWriteTxns + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           calib_done_i,
  input  logic           drain_req_i,
  input  axi_req_t       slv_req_i,
  output axi_resp_t      slv_rsp_o,
  output axi_req_t       mst_req_o,
  input  axi_resp_t      mst_rsp_i,
  output logic [RdW-1:0] rd_outstanding_o,
  output logic [WrW-1:0] wr_outstanding_o,
  output logic           drained_o,
  output logic           timeout_o
);
  typedef enum logic [1:0] {WAIT_CALIB, RUN, DRAIN, DRAINED} state_e;
  state_e state_q, state_d;
  logic [RdW-1:0] rd_cnt_q, rd_cnt_d;
  logic [WrW-1:0] wr_cnt_q, wr_cnt_d;
  logic allow_ar, allow_aw, allow_w;
  logic rd_inc, rd_dec, wr_inc, wr_dec;
  assign allow_ar = (state_q == RUN) && (rd_cnt_q < RdW'(MaxReadTxns));
  assign allow_aw = (state_q == RUN) && (wr_cnt_q < WrW'(MaxWriteTxns));
  assign allow_w  = (state_q == RUN) || (state_q == DRAIN);
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & allow_ar;
    mst_req_o.aw_valid = slv_req_i.aw_valid & allow_aw;
    mst_req_o.w_valid  = slv_req_i.w_valid & allow_w;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & allow_ar;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & allow_aw;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & allow_w;
  end
  assign rd_inc = slv_req_i.ar_valid & allow_ar & mst_rsp_i.ar_ready;
  assign rd_dec = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
  assign wr_inc = slv_req_i.aw_valid & allow_aw & mst_rsp_i.aw_ready;
  assign wr_dec = mst_rsp_i.b_valid & slv_req_i.b_ready;
  // A lone decrement at zero is a protocol error; the count holds at zero instead of wrapping.
  always_comb begin
    rd_cnt_d = (rd_inc && !rd_dec) ? rd_cnt_q + RdW'(1) :
               (rd_dec && !rd_inc && rd_cnt_q != '0) ? rd_cnt_q - RdW'(1) : rd_cnt_q;
    wr_cnt_d = (wr_inc && !wr_dec) ? wr_cnt_q + WrW'(1) :
               (wr_dec && !wr_inc && wr_cnt_q != '0) ? wr_cnt_q - WrW'(1) : wr_cnt_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_CALIB: state_d = calib_done_i ? RUN : WAIT_CALIB;
      RUN:        state_d = (drain_req_i || !calib_done_i) ? DRAIN : RUN;
      DRAIN:      state_d = (rd_cnt_q == '0 && wr_cnt_q == '0 && !rd_dec && !wr_dec) ? DRAINED : DRAIN;
      DRAINED:    state_d = !calib_done_i ? WAIT_CALIB : !drain_req_i ? RUN : DRAINED;
      default:    state_d = WAIT_CALIB;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= WAIT_CALIB;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      assert (!(rd_dec && !rd_inc && rd_cnt_q == '0) && !(wr_dec && !wr_inc && wr_cnt_q == '0));
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  assign rd_outstanding_o = rd_cnt_q;
  assign wr_outstanding_o = wr_cnt_q;
  assign drained_o        = state_q == DRAINED;
`ifdef DRAM_TXN_GATE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic timeout_q, timeout_d;
  logic rsp_hs;
  // Any R beat or B counts as forward progress, not just the last beat of a burst.
  assign rsp_hs = (mst_rsp_i.r_valid & slv_req_i.r_ready) | wr_dec;
  always_comb begin
    tmo_cnt_d = (rsp_hs || (rd_cnt_q == '0 && wr_cnt_q == '0)) ? '0 :
                (tmo_cnt_q == TmoW'(TimeoutCycles)) ? tmo_cnt_q : tmo_cnt_q + TmoW'(1);
    timeout_d = timeout_q | (tmo_cnt_d == TmoW'(TimeoutCycles));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_dram_txn_gate.sv
// tb_dram_txn_gate: directed plus random checking of dram_txn_gate against a queue-based reference model
module tb_dram_txn_gate;
  import dram_txn_gate_pkg::*;
  localparam int T = 100;
  localparam int MaxRd = 8;
  localparam int MaxWr = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic calib = 1'b0;
  logic drain = 1'b0;
  axi_req_t  sreq, mreq;
  axi_resp_t srsp, mrsp;
  logic [3:0] rd_o, wr_o;
  logic drained, tmo;
  int total = 0;
  int bad = 0;
  logic [3:0] rd_q[$];
  logic [3:0] wr_q[$];
  string mode = "WAIT";
  int idle = 0;
  bit tflag = 1'b0;
  always #5 clk = ~clk;
  dram_txn_gate #(.MaxReadTxns(MaxRd), .MaxWriteTxns(MaxWr), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .calib_done_i(calib), .drain_req_i(drain),
    .slv_req_i(sreq), .slv_rsp_o(srsp), .mst_req_o(mreq), .mst_rsp_i(mrsp),
    .rd_outstanding_o(rd_o), .wr_outstanding_o(wr_o), .drained_o(drained), .timeout_o(tmo)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic payload();
    sreq.ar.id = 4'($urandom); sreq.ar.addr = $urandom; sreq.ar.len = 8'($urandom);
    sreq.aw.id = 4'($urandom); sreq.aw.addr = $urandom; sreq.aw.len = 8'($urandom);
    sreq.w.data = $urandom; sreq.w.strb = 4'($urandom); sreq.w.last = 1'($urandom);
    mrsp.b.id = 4'($urandom); mrsp.b.resp = 2'($urandom);
    mrsp.r.id = 4'($urandom); mrsp.r.data = $urandom; mrsp.r.resp = 2'($urandom);
  endtask
  task automatic idle_bus();
    sreq = '0; mrsp = '0;
    payload();
    sreq.r_ready = 1'b1; sreq.b_ready = 1'b1;
    mrsp.ar_ready = 1'b1; mrsp.aw_ready = 1'b1; mrsp.w_ready = 1'b1;
  endtask
  // Checks outputs mid-cycle against the model, then advances the model across one clock edge.
  task automatic step();
    bit a_ar, a_aw, a_w, ar_hs, aw_hs, r_hs, rl_hs, b_hs;
    string nmode;
    #4;
    a_ar = mode == "RUN" && rd_q.size() < MaxRd;
    a_aw = mode == "RUN" && wr_q.size() < MaxWr;
    a_w  = mode == "RUN" || mode == "DRAIN";
    chk("ar_valid", 64'(mreq.ar_valid), 64'(sreq.ar_valid & a_ar));
    chk("ar_ready", 64'(srsp.ar_ready), 64'(mrsp.ar_ready & a_ar));
    chk("aw_valid", 64'(mreq.aw_valid), 64'(sreq.aw_valid & a_aw));
    chk("aw_ready", 64'(srsp.aw_ready), 64'(mrsp.aw_ready & a_aw));
    chk("w_valid", 64'(mreq.w_valid), 64'(sreq.w_valid & a_w));
    chk("w_ready", 64'(srsp.w_ready), 64'(mrsp.w_ready & a_w));
    chk("ar_pay", 64'(mreq.ar), 64'(sreq.ar));
    chk("aw_pay", 64'(mreq.aw), 64'(sreq.aw));
    chk("w_pay", 64'(mreq.w), 64'(sreq.w));
    chk("rb_ready", 64'({mreq.r_ready, mreq.b_ready}), 64'({sreq.r_ready, sreq.b_ready}));
    chk("r_pass", 64'({srsp.r_valid, srsp.r}), 64'({mrsp.r_valid, mrsp.r}));
    chk("b_pass", 64'({srsp.b_valid, srsp.b}), 64'({mrsp.b_valid, mrsp.b}));
    chk("rd_out", 64'(rd_o), 64'(rd_q.size()));
    chk("wr_out", 64'(wr_o), 64'(wr_q.size()));
    chk("drained", 64'(drained), 64'(mode == "DRAINED"));
    chk("timeout", 64'(tmo), 64'(tflag));
    ar_hs = sreq.ar_valid & a_ar & mrsp.ar_ready;
    aw_hs = sreq.aw_valid & a_aw & mrsp.aw_ready;
    r_hs  = mrsp.r_valid & sreq.r_ready;
    rl_hs = r_hs & mrsp.r.last;
    b_hs  = mrsp.b_valid & sreq.b_ready;
    nmode = mode;
    if (!rst_n) nmode = "WAIT";
    else if (mode == "WAIT" && calib) nmode = "RUN";
    else if (mode == "RUN" && (drain || !calib)) nmode = "DRAIN";
    else if (mode == "DRAIN" && rd_q.size() == 0 && wr_q.size() == 0) nmode = "DRAINED";
    else if (mode == "DRAINED") nmode = !calib ? "WAIT" : !drain ? "RUN" : "DRAINED";
`ifdef DRAM_TXN_GATE_TIMEOUT_EN
    if (rd_q.size() + wr_q.size() == 0 || r_hs || b_hs) idle = 0;
    else if (idle < T) idle++;
    if (idle == T && rst_n) tflag = 1'b1;
`endif
    if (rst_n) begin
      if (ar_hs) rd_q.push_back(sreq.ar.id);
      if (rl_hs) void'(rd_q.pop_front());
      if (aw_hs) wr_q.push_back(sreq.aw.id);
      if (b_hs) void'(wr_q.pop_front());
    end
    mode = nmode;
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle_bus();
    sreq.ar_valid = 1'b1;
    #6;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("tp1_held_cnt", 64'(rd_o), 64'd0);
    calib = 1'b1;
    step();
    chk("tp1_fwd", 64'(mreq.ar_valid), 64'd1);
    step();
    sreq.ar_valid = 1'b0;
    chk("tp1_cnt", 64'(rd_o), 64'd1);
    sreq.ar_valid = 1'b1;
    repeat (10) begin payload(); step(); end
    chk("tp2_cnt", 64'(rd_o), 64'd8);
    chk("tp2_stall", 64'(srsp.ar_ready), 64'd0);
    mrsp.r_valid = 1'b1; mrsp.r.last = 1'b1;
    step();
    mrsp.r_valid = 1'b0;
    step();
    sreq.ar_valid = 1'b0;
    chk("tp2_refill", 64'(rd_o), 64'd8);
    mrsp.r_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mrsp.r.last = (i % 3) != 0;
      step();
    end
    mrsp.r_valid = 1'b0;
    chk("tp2_empty", 64'(rd_o), 64'd0);
    sreq.aw_valid = 1'b1;
    repeat (3) step();
    mrsp.b_valid = 1'b1;
    step();
    chk("tp3_simul", 64'(wr_o), 64'd3);
    sreq.aw_valid = 1'b0;
    repeat (2) step();
    mrsp.b_valid = 1'b0;
    sreq.ar_valid = 1'b1;
    repeat (2) step();
    sreq.ar_valid = 1'b0;
    chk("tp4_pre", 64'({rd_o, wr_o}), 64'h21);
    drain = 1'b1;
    step();
    sreq.ar_valid = 1'b1; sreq.aw_valid = 1'b1; sreq.w_valid = 1'b1;
    step();
    chk("tp4_ar_blk", 64'(mreq.ar_valid), 64'd0);
    chk("tp4_aw_blk", 64'(mreq.aw_valid), 64'd0);
    chk("tp4_w_pass", 64'(mreq.w_valid), 64'd1);
    mrsp.r_valid = 1'b1; mrsp.r.last = 1'b1;
    step();
    mrsp.b_valid = 1'b1;
    step();
    mrsp.r_valid = 1'b0; mrsp.b_valid = 1'b0;
    chk("tp4_not_yet", 64'(drained), 64'd0);
    step();
    chk("tp4_drained", 64'(drained), 64'd1);
    sreq.ar_valid = 1'b0; sreq.aw_valid = 1'b0; sreq.w_valid = 1'b0;
    drain = 1'b0;
    step();
    chk("tp4_resume", 64'(drained), 64'd0);
    sreq.ar_valid = 1'b1;
    step();
    sreq.ar_valid = 1'b0;
    chk("tp4_traffic", 64'(rd_o), 64'd1);
    calib = 1'b0;
    step();
    mrsp.r_valid = 1'b1;
    step();
    mrsp.r_valid = 1'b0;
    step();
    chk("tp5_drained", 64'(drained), 64'd1);
    step();
    chk("tp5_wait", 64'(drained), 64'd0);
    calib = 1'b1;
    step();
    sreq.ar_valid = 1'b1;
    step();
    sreq.ar_valid = 1'b0;
    repeat (99) step();
    chk("tp6_before", 64'(tmo), 64'd0);
    step();
`ifdef DRAM_TXN_GATE_TIMEOUT_EN
    chk("tp6_set", 64'(tmo), 64'd1);
`else
    chk("tp6_off", 64'(tmo), 64'd0);
`endif
    mrsp.r_valid = 1'b1;
    step();
    mrsp.r_valid = 1'b0;
    step();
`ifdef DRAM_TXN_GATE_TIMEOUT_EN
    chk("tp6_sticky", 64'(tmo), 64'd1);
`else
    chk("tp6_off2", 64'(tmo), 64'd0);
`endif
    for (int i = 0; i < 600; i++) begin
      payload();
      if ($urandom_range(39) == 0) calib = ~calib;
      if ($urandom_range(24) == 0) drain = ~drain;
      sreq.ar_valid = 1'($urandom); sreq.aw_valid = 1'($urandom); sreq.w_valid = 1'($urandom);
      sreq.r_ready = 1'($urandom); sreq.b_ready = 1'($urandom);
      mrsp.ar_ready = 1'($urandom); mrsp.aw_ready = 1'($urandom); mrsp.w_ready = 1'($urandom);
      mrsp.r_valid = rd_q.size() > 0 && $urandom_range(2) == 0;
      mrsp.r.last = 1'($urandom);
      mrsp.b_valid = wr_q.size() > 0 && $urandom_range(2) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
